// File: rtl/mips_pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pc_pkg
// Description : Shared types and constants for the PC / instruction-fetch
//               front end: fetch FSM state encoding, next-PC select
//               encoding and the sequential PC step.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pc_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        ERROR = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        SEL_PC4 = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } pc_sel_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// ============================================================================
// Module      : pc_target_calc
// Description : Combinational next-PC generation. Computes PC+4, the
//               PC-relative branch target and the pseudo-direct jump target,
//               then selects with priority JumpReg > Jump > PCSrc > PC+4.
//               All arithmetic wraps modulo 2^32.
// Ports       : i_pc          current PC
//               i_pc_src      take branch
//               i_jump        J/JAL jump
//               i_jump_reg    JR jump
//               i_branch_imm  signed word offset
//               i_jump_idx    26-bit jump index
//               i_reg_target  register jump target
//               o_pc_plus4    PC + 4
//               o_next_pc     selected target (low bits unmodified)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_target_calc
    import mips_pc_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_pc_src,
    input  logic        i_jump,
    input  logic        i_jump_reg,
    input  logic [15:0] i_branch_imm,
    input  logic [25:0] i_jump_idx,
    input  logic [31:0] i_reg_target,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_next_pc
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_tgt;
    logic [31:0] w_jump_tgt;
    pc_sel_t     w_sel;

    assign w_pc_plus4   = i_pc + PC_STEP;
    // Word offset: sign-extend and scale by 4 before adding to PC+4.
    assign w_branch_tgt = w_pc_plus4 + {{14{i_branch_imm[15]}}, i_branch_imm, 2'b00};
    // Jump stays within the current 256 MB region of PC+4.
    assign w_jump_tgt   = {w_pc_plus4[31:28], i_jump_idx, 2'b00};

    always_comb begin
        w_sel = SEL_PC4;
        if (i_jump_reg)
            w_sel = SEL_JR;
        else if (i_jump)
            w_sel = SEL_J;
        else if (i_pc_src)
            w_sel = SEL_BR;
    end

    always_comb begin
        o_next_pc = w_pc_plus4;
        case (w_sel)
            SEL_JR:  o_next_pc = i_reg_target;
            SEL_J:   o_next_pc = w_jump_tgt;
            SEL_BR:  o_next_pc = w_branch_tgt;
            default: o_next_pc = w_pc_plus4;
        endcase
    end

    assign o_pc_plus4 = w_pc_plus4;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program-counter register and instruction-fetch sequencer.
//               Drives a req/ready handshake to instruction memory, holds PC
//               while memory waits or the pipeline stalls, and loads the
//               next PC on each completed handshake. A fetch that waits too
//               long sets a sticky FetchErr; only rst clears it.
// Config      : PC_ALIGN_CHECK_EN - when defined, a misaligned next PC
//               (reachable only via JumpReg) redirects to EXC_VECTOR and
//               pulses AlignErr. When undefined, next PC bits [1:0] are
//               forced to zero and AlignErr is tied low.
// Ports       : clk, rst (sync, active high)
//               PCSrc/Jump/JumpReg, BranchImm, JumpIdx, RegTarget : next PC
//               Stall        hold PC, suppress new fetch
//               imem_req/imem_addr/imem_ready : memory handshake
//               InstrValid   handshake completes this cycle
//               PC, PCPlus4  current PC and PC + 4
//               FetchErr     sticky timeout flag
//               AlignErr     one-cycle misaligned-target pulse
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] EXC_VECTOR     = 32'h0000_0080
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [15:0] BranchImm,
    input  logic [25:0] JumpIdx,
    input  logic [31:0] RegTarget,
    input  logic        Stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        FetchErr,
    output logic        AlignErr
);

    localparam logic [7:0] c_timeout = 8'(TIMEOUT_CYCLES);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [7:0]   r_wait_cnt;
    logic         r_fetch_err;
    logic         r_align_err;

    logic [31:0]  w_next_raw;
    logic [31:0]  w_next_pc;
    logic         w_misaligned;
    logic         w_req;
    logic         w_handshake;
    logic         w_pc_load;

    pc_target_calc u_target (
        .i_pc         (r_pc),
        .i_pc_src     (PCSrc),
        .i_jump       (Jump),
        .i_jump_reg   (JumpReg),
        .i_branch_imm (BranchImm),
        .i_jump_idx   (JumpIdx),
        .i_reg_target (RegTarget),
        .o_pc_plus4   (PCPlus4),
        .o_next_pc    (w_next_raw)
    );

`ifdef PC_ALIGN_CHECK_EN
    assign w_misaligned = |w_next_raw[1:0];
    assign w_next_pc    = w_next_raw;
`else
    logic w_unused;
    assign w_misaligned = 1'b0;
    assign w_next_pc    = {w_next_raw[31:2], 2'b00};
    assign w_unused     = ^{EXC_VECTOR, w_next_raw[1:0]};
`endif

    // Once in WAIT the request is committed; Stall can no longer withdraw it.
    always_comb begin
        w_req = 1'b0;
        case (r_state)
            FETCH:   w_req = ~Stall;
            WAIT:    w_req = 1'b1;
            default: w_req = 1'b0;
        endcase
    end

    assign w_handshake = w_req & imem_ready;
    // A stalled handshake (only possible from WAIT) refetches the same PC.
    assign w_pc_load   = w_handshake & ~Stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RESET;
            r_pc        <= RESET_PC;
            r_wait_cnt  <= 8'd0;
            r_fetch_err <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_align_err <= 1'b0;

            if (w_pc_load) begin
                if (w_misaligned) begin
`ifdef PC_ALIGN_CHECK_EN
                    r_pc        <= EXC_VECTOR;
`endif
                    r_align_err <= 1'b1;
                end else begin
                    r_pc <= w_next_pc;
                end
            end

            case (r_state)
                RESET: r_state <= FETCH;
                FETCH: begin
                    if (w_req && !imem_ready) begin
                        r_state    <= WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                WAIT: begin
                    if (imem_ready) begin
                        r_state    <= FETCH;
                        r_wait_cnt <= 8'd0;
                    end else if (r_wait_cnt >= c_timeout) begin
                        r_state     <= ERROR;
                        r_fetch_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ERROR:   r_fetch_err <= 1'b1;
                default: r_state <= RESET;
            endcase
        end
    end

    assign imem_req   = w_req;
    assign imem_addr  = r_pc;
    assign InstrValid = w_handshake;
    assign PC         = r_pc;
    assign FetchErr   = r_fetch_err;
    assign AlignErr   = r_align_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed self-checking bench for pc_fetch_unit. Inputs are
//               driven and outputs sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pc_fetch_unit;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [31:0] c_align_pc  = 32'h0000_0080;
    localparam logic [31:0] c_align_err = 32'd1;
`else
    localparam logic [31:0] c_align_pc  = 32'h0000_0200;
    localparam logic [31:0] c_align_err = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrc;
    logic        Jump;
    logic        JumpReg;
    logic [15:0] BranchImm;
    logic [25:0] JumpIdx;
    logic [31:0] RegTarget;
    logic        Stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        FetchErr;
    logic        AlignErr;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_unit #(
        .RESET_PC       (32'h0000_0000),
        .TIMEOUT_CYCLES (16),
        .EXC_VECTOR     (32'h0000_0080)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PCSrc      (PCSrc),
        .Jump       (Jump),
        .JumpReg    (JumpReg),
        .BranchImm  (BranchImm),
        .JumpIdx    (JumpIdx),
        .RegTarget  (RegTarget),
        .Stall      (Stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .InstrValid (InstrValid),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .FetchErr   (FetchErr),
        .AlignErr   (AlignErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; PCSrc = 1'b0; Jump = 1'b0; JumpReg = 1'b0;
        BranchImm = 16'h0; JumpIdx = 26'h0; RegTarget = 32'h0;
        Stall = 1'b0; imem_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pc", PC, 32'h0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_ferr", {31'd0, FetchErr}, 32'd0);
        check("rst_aerr", {31'd0, AlignErr}, 32'd0);
        rst = 1'b0;
        #1;
        check("bubble_req", {31'd0, imem_req}, 32'd0);

        // Sequential fetch: 0, 4, 8, C
        @(negedge clk);
        check("seq_pc0", PC, 32'h0);
        check("seq_req", {31'd0, imem_req}, 32'd1);
        check("seq_valid", {31'd0, InstrValid}, 32'd1);
        @(negedge clk); check("seq_pc4", PC, 32'h4);
        @(negedge clk); check("seq_pc8", PC, 32'h8);
        @(negedge clk); check("seq_pcC", PC, 32'hC);

        // Branch backward and forward from 0x100
        JumpReg = 1'b1; RegTarget = 32'h100;
        @(negedge clk); check("jr_100", PC, 32'h100);
        JumpReg = 1'b0; PCSrc = 1'b1; BranchImm = 16'hFFFE;
        @(negedge clk); check("br_back", PC, 32'h0FC);
        PCSrc = 1'b0; JumpReg = 1'b1; RegTarget = 32'h100;
        @(negedge clk);
        JumpReg = 1'b0; PCSrc = 1'b1; BranchImm = 16'h0003;
        @(negedge clk); check("br_fwd", PC, 32'h110);

        // All selects high: JumpReg wins
        Jump = 1'b1; JumpReg = 1'b1; JumpIdx = 26'h3FF_FFFF; RegTarget = 32'h400;
        @(negedge clk); check("prio_jr", PC, 32'h400);

        // Jump only, within the 0x1000_0000 region
        PCSrc = 1'b0; Jump = 1'b0; RegTarget = 32'h1000_0000;
        @(negedge clk);
        JumpReg = 1'b0; Jump = 1'b1; JumpIdx = 26'h10;
        @(negedge clk);
        check("jump", PC, 32'h1000_0040);
        check("pcplus4", PCPlus4, 32'h1000_0044);

        // Wraparound of PC+4
        Jump = 1'b0; JumpReg = 1'b1; RegTarget = 32'hFFFF_FFFC;
        @(negedge clk);
        check("wrap_plus4", PCPlus4, 32'h0);
        JumpReg = 1'b0;
        @(negedge clk); check("wrap_pc", PC, 32'h0);

        // Stall in FETCH: no request, controls ignored, PC held
        Stall = 1'b1; JumpReg = 1'b1; RegTarget = 32'h500;
        #1;
        check("stall_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk); check("stall_pc", PC, 32'h0);

        // Wait states at 0x20
        Stall = 1'b0; RegTarget = 32'h20;
        @(negedge clk); check("w_pc20", PC, 32'h20);
        JumpReg = 1'b0; imem_ready = 1'b0;
        #1;
        check("w_req1", {31'd0, imem_req}, 32'd1);
        check("w_valid0", {31'd0, InstrValid}, 32'd0);
        @(negedge clk);
        check("w_addr2", imem_addr, 32'h20);
        check("w_req2", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        check("w_addr3", imem_addr, 32'h20);
        check("w_req3", {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        #1;
        check("w_valid1", {31'd0, InstrValid}, 32'd1);
        @(negedge clk); check("w_pc24", PC, 32'h24);

        // Stall during WAIT: request held, handshake does not advance PC
        JumpReg = 1'b1; RegTarget = 32'h20;
        @(negedge clk);
        JumpReg = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        Stall = 1'b1; imem_ready = 1'b1; JumpReg = 1'b1; RegTarget = 32'h300;
        #1;
        check("ws_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        check("ws_pc", PC, 32'h20);
        check("ws_req_after", {31'd0, imem_req}, 32'd0);

        // Misaligned register target
        Stall = 1'b0; RegTarget = 32'h202;
        @(negedge clk);
        check("align_pc", PC, c_align_pc);
        check("align_err", {31'd0, AlignErr}, c_align_err);
        JumpReg = 1'b0;
        @(negedge clk);
        check("align_pulse_end", {31'd0, AlignErr}, 32'd0);
        check("align_next", PC, c_align_pc + 32'd4);

        // Timeout: memory never ready
        imem_ready = 1'b0;
        repeat (16) @(negedge clk);
        check("to_pre_ferr", {31'd0, FetchErr}, 32'd0);
        check("to_pre_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        check("to_ferr", {31'd0, FetchErr}, 32'd1);
        check("to_req", {31'd0, imem_req}, 32'd0);
        imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("to_sticky", {31'd0, FetchErr}, 32'd1);
        check("to_pc_held", PC, c_align_pc + 32'd4);

        // Reset clears the error
        rst = 1'b1;
        @(negedge clk);
        check("rst2_ferr", {31'd0, FetchErr}, 32'd0);
        check("rst2_pc", PC, 32'h0);
        check("rst2_req", {31'd0, imem_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
